// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - state encoding, ISA field constants and decode helper for cpu_ctrl
package cpu_pkg;

  // Sequencer states
  localparam logic [2:0] S_WAIT      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_WRITE_IMM = 3'd2;
  localparam logic [2:0] S_GET_A     = 3'd3;
  localparam logic [2:0] S_GET_B     = 3'd4;
  localparam logic [2:0] S_ALU       = 3'd5;
  localparam logic [2:0] S_WRITE_RD  = 3'd6;

  // Opcode classes
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Sub-operations within each opcode class
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // Writeback source selects
  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b01;

  // State that follows DECODE for a given encoding; unsupported encodings go back to WAIT
  function automatic logic [2:0] decode_next(input logic [2:0] opcode, input logic [1:0] op);
    if (opcode == OPC_MOV && op == OP_MOV_IMM) return S_WRITE_IMM;
    if (opcode == OPC_MOV && op == OP_MOV_REG) return S_GET_B;
    if (opcode == OPC_ALU && op == OP_MVN)     return S_GET_B;
    if (opcode == OPC_ALU && (op == OP_ADD || op == OP_CMP || op == OP_AND)) return S_GET_A;
    return S_WAIT;
  endfunction

endpackage

// File: rtl/instr_dec.sv
// rtl/instr_dec.sv - combinational split of the instruction register into its fields
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  shift,
  output logic [15:0] sximm8
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];
  assign shift  = ir[4:3];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - instruction register and Moore sequencer driving register file and datapath
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8
);

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic [15:0] ir;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [2:0]  rm;

  instr_dec u_dec (
    .ir     (ir),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .shift  (shift),
    .sximm8 (sximm8)
  );

  // IR only accepts a new word while idle, so DECODE sees the word captured with s
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= 16'h0000;
    end else begin
      if (state == S_WAIT && load) ir <= in;
      state <= next_state;
    end
  end

  // Next-state selection; only CMP skips the register writeback after the ALU step
  always_comb begin
    next_state = S_WAIT;
    case (state)
      S_WAIT:      next_state = s ? S_DECODE : S_WAIT;
      S_DECODE:    next_state = decode_next(opcode, op);
      S_GET_A:     next_state = S_GET_B;
      S_GET_B:     next_state = S_ALU;
      S_ALU:       next_state = (opcode == OPC_ALU && op == OP_CMP) ? S_WAIT : S_WRITE_RD;
      S_WRITE_IMM: next_state = S_WAIT;
      S_WRITE_RD:  next_state = S_WAIT;
      default:     next_state = S_WAIT;
    endcase
  end

  assign w    = (state == S_WAIT);
  assign bsel = 1'b0;

  // Moore strobes and selects, each state's strobe lives for exactly one cycle
  always_comb begin
    readnum  = 3'b000;
    writenum = 3'b000;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    vsel     = VSEL_C;
    ALUop    = 2'b00;
    case (state)
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        loadc = 1'b1;
        ALUop = op;
        asel  = (opcode == OPC_MOV && op == OP_MOV_REG) || (opcode == OPC_ALU && op == OP_MVN);
        loads = (opcode == OPC_ALU && op == OP_CMP);
      end
      S_WRITE_RD: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
      end
      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - scoreboard bench for cpu_ctrl with directed instruction vectors
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in = 16'h0000;
  logic        load = 1'b0;
  logic        s = 1'b0;
  logic        w;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8;

  typedef struct packed {
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [5:0]  flags;   // write, loada, loadb, loadc, loads, asel
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] sximm8;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  cpu_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .load     (load),
    .s        (s),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .vsel     (vsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm8   (sximm8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] rn, input logic [2:0] wn, input logic [5:0] f,
                              input logic [1:0] vs, input logic [1:0] sh, input logic [1:0] op,
                              input logic [15:0] imm);
    exp_t e;
    e.readnum = rn; e.writenum = wn; e.flags = f; e.vsel = vs;
    e.shift = sh; e.aluop = op; e.sximm8 = imm;
    return e;
  endfunction

  function automatic exp_t sample();
    return mk(readnum, writenum, {write, loada, loadb, loadc, loads, asel}, vsel, shift, ALUop, sximm8);
  endfunction

  // Monitor: every cycle carrying a strobe must match the next scoreboard entry
  always @(negedge clk) begin
    if (!reset && (write || loada || loadb || loadc || loads)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 64'(sample()), 64'd0);
      end else begin
        chk("strobe_cycle", 64'(sample()), 64'(exp_q.pop_front()));
      end
      chk("bsel", 64'(bsel), 64'd0);
    end
  end

  // Issue one instruction and count edges from the s-sampling edge until w returns
  task automatic run_instr(input string name, input logic [15:0] instr, input bit do_load,
                           input int exp_edges, input int inj_edge);
    int edges;
    bit done;
    @(negedge clk);
    in = instr; load = do_load; s = 1'b1;
    edges = 0; done = 1'b0;
    while (!done && edges < 20) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) begin
        load = 1'b0; s = 1'b0;
      end
      if (inj_edge != 0 && edges == inj_edge) begin
        in = 16'hD0FF; load = 1'b1; s = 1'b1;
      end else if (inj_edge != 0 && edges == inj_edge + 1) begin
        load = 1'b0; s = 1'b0;
      end
      if (w) done = 1'b1;
    end
    load = 1'b0; s = 1'b0;
    chk({name, "_edges"}, 64'(edges), 64'(exp_edges));
  endtask

  initial begin
    int edges;
    // reset state
    #2;
    chk("rst_w", 64'(w), 64'd1);
    chk("rst_outputs", 64'(sample()), 64'(mk(3'd0, 3'd0, 6'b0, 2'b00, 2'b00, 2'b00, 16'h0000)));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // MOV R0,#7
    exp_q.push_back(mk(3'd0, 3'd0, 6'b100000, 2'b01, 2'b00, 2'b00, 16'h0007));
    run_instr("mov_imm7", 16'hD007, 1'b1, 3, 0);

    // MOV R1,#-2
    exp_q.push_back(mk(3'd0, 3'd1, 6'b100000, 2'b01, 2'b11, 2'b00, 16'hFFFE));
    run_instr("mov_imm_neg", 16'hD1FE, 1'b1, 3, 0);

    // ADD R2,R1,R0,LSL#1 with a load attempt during GET_B that must be ignored
    exp_q.push_back(mk(3'd1, 3'd0, 6'b010000, 2'b00, 2'b01, 2'b00, 16'h0048));
    exp_q.push_back(mk(3'd0, 3'd0, 6'b001000, 2'b00, 2'b01, 2'b00, 16'h0048));
    exp_q.push_back(mk(3'd0, 3'd0, 6'b000100, 2'b00, 2'b01, 2'b00, 16'h0048));
    exp_q.push_back(mk(3'd0, 3'd2, 6'b100000, 2'b00, 2'b01, 2'b00, 16'h0048));
    run_instr("add", 16'hA148, 1'b1, 6, 3);
    chk("ir_held_after_add", 64'(sximm8), 64'h0048);

    // CMP R1,R0: status load, no writeback
    exp_q.push_back(mk(3'd1, 3'd0, 6'b010000, 2'b00, 2'b00, 2'b00, 16'h0000));
    exp_q.push_back(mk(3'd0, 3'd0, 6'b001000, 2'b00, 2'b00, 2'b00, 16'h0000));
    exp_q.push_back(mk(3'd0, 3'd0, 6'b000110, 2'b00, 2'b00, 2'b01, 16'h0000));
    run_instr("cmp", 16'hA900, 1'b1, 5, 0);

    // MVN R7,R1
    exp_q.push_back(mk(3'd1, 3'd0, 6'b001000, 2'b00, 2'b00, 2'b00, 16'hFFE1));
    exp_q.push_back(mk(3'd0, 3'd0, 6'b000101, 2'b00, 2'b00, 2'b11, 16'hFFE1));
    exp_q.push_back(mk(3'd0, 3'd7, 6'b100000, 2'b00, 2'b00, 2'b00, 16'hFFE1));
    run_instr("mvn", 16'hB8E1, 1'b1, 5, 0);

    // MOV R5,R2
    exp_q.push_back(mk(3'd2, 3'd0, 6'b001000, 2'b00, 2'b00, 2'b00, 16'hFFA2));
    exp_q.push_back(mk(3'd0, 3'd0, 6'b000101, 2'b00, 2'b00, 2'b00, 16'hFFA2));
    exp_q.push_back(mk(3'd0, 3'd5, 6'b100000, 2'b00, 2'b00, 2'b00, 16'hFFA2));
    run_instr("mov_reg", 16'hC0A2, 1'b1, 5, 0);

    // Unsupported encodings: no strobes
    run_instr("unsup_e000", 16'hE000, 1'b1, 2, 0);
    run_instr("unsup_c800", 16'hC800, 1'b1, 2, 0);

    // Reset in the middle of GET_B of an ADD
    exp_q.push_back(mk(3'd1, 3'd0, 6'b010000, 2'b00, 2'b01, 2'b00, 16'h0048));
    @(negedge clk);
    in = 16'hA148; load = 1'b1; s = 1'b1;
    edges = 0;
    while (edges < 3) begin
      @(posedge clk);
      edges++;
      #1;
      load = 1'b0; s = 1'b0;
    end
    chk("pre_rst_loadb", 64'(loadb), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_w", 64'(w), 64'd1);
    chk("midrst_loadb", 64'(loadb), 64'd0);
    chk("midrst_ir", 64'({sximm8, shift}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_w", 64'(w), 64'd1);
    // s without load: in is not captured, IR=0 decodes as unsupported
    run_instr("post_rst_unsup", 16'hA148, 1'b0, 2, 0);
    chk("post_rst_ir", 64'(sximm8), 64'h0000);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Instruction register plus Moore sequencer for the simple RISC datapath. It sits directly upstream of the register file and datapath. It latches a 16-bit instruction, decodes it, and drives the register file's readnum/writenum/write together with the datapath load strobes and selects, one step per clock. It returns to an idle state that asserts `w` when the instruction is complete.

## Interface
Parameters: none (widths fixed by ISA).

Ports. Reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces WAIT and clears the IR
- in  in  16  instruction word
- load  in  1  capture `in` into the IR (honoured in WAIT only)
- s  in  1  start execution (honoured in WAIT only)
- w  out  1  high iff state is WAIT
- readnum  out  3  register file read select
- writenum  out  3  register file write select
- write  out  1  register file write enable
- loada, loadb, loadc, loads  out  1 each  datapath A/B/C/status load enables
- asel  out  1  1 = A operand forced to 0
- bsel  out  1  1 = B operand is sximm5 (always 0 in this ISA subset)
- vsel  out  2  writeback source: 00 = C, 01 = sximm8, 10 and 11 reserved
- shift  out  2  shifter op, IR[4:3]
- ALUop  out  2  IR[12:11] in ALU state; 00 otherwise
- sximm8  out  16  sign-extended IR[7:0]

## Operation
IR fields:
- opcode = IR[15:13]
- op = IR[12:11]
- Rn = IR[10:8]
- Rd = IR[7:5]
- Rm = IR[2:0]

States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_RD.

Transitions:
- WAIT → DECODE when s=1; otherwise stay in WAIT.
- DECODE:
  - 110/10 (MOV Rn,#imm8) → WRITE_IMM
  - 110/00 (MOV Rd,Rm{,sh}) → GET_B
  - 101/11 (MVN) → GET_B
  - 101/00, 101/01, 101/10 (ADD, CMP, AND) → GET_A
  - any other encoding → WAIT, with no strobes issued
- GET_A → GET_B → ALU.
- ALU → WAIT for CMP; ALU → WRITE_RD for all other instructions.
- WRITE_IMM → WAIT. WRITE_RD → WAIT.

Per-state outputs (Moore). Any output not listed is 0, readnum/writenum are 3'b000, and vsel is 00.
- GET_A: readnum=Rn, loada=1
- GET_B: readnum=Rm, loadb=1
- ALU: loadc=1; ALUop=op; asel=1 for MOV-reg and MVN; loads=1 for CMP only
- WRITE_RD: writenum=Rd, vsel=00, write=1
- WRITE_IMM: writenum=Rn, vsel=01, write=1

Always driven regardless of state: shift=IR[4:3] and sximm8={{8{IR[7]}},IR[7:0]}.

Rules:
- The IR loads on an edge with load=1 only while in WAIT. During execution, load and s are ignored.
- If load and s are both 1 in WAIT, the new IR is captured and DECODE uses the new instruction.

## Timing
- Reset: state=WAIT, IR=16'h0000, w=1, all strobes 0, readnum=writenum=0, vsel=00, sximm8=0000. Reset takes effect immediately, without waiting for a clock edge. Reset mid-operation aborts the instruction and issues no further strobes.
- Edge counts below are from the edge that samples s=1 until w=1 again:
  - MOV imm: 3 edges
  - MOV reg and MVN: 5 edges
  - CMP: 5 edges
  - ADD and AND: 6 edges
  - unsupported encoding: 2 edges
- Each strobe is high for exactly one cycle. The consumer (register file or datapath register) captures on the rising edge that ends that cycle.
- w is registered state only; it has no combinational path from s.

## Structure
- Package `cpu_pkg`:
  - 3-bit state encoding constants
  - opcode/op constants: OPC_MOV=3'b110, OPC_ALU=3'b101
  - vsel constants: VSEL_C=2'b00, VSEL_IMM8=2'b01
- Sub-module `instr_dec` (purely combinational): IR → opcode, op, Rn, Rd, Rm, shift, sximm8.
- The state register and IR use asynchronous reset. Output logic is a case on state.

## Test plan
- MOV R0,#7: load in=16'hD007, then s. Expect WRITE_IMM with writenum=0, vsel=01, sximm8=16'h0007, write=1 for one cycle; w=1 three edges after s.
- MOV R1,#-2: in=16'hD1FE. Expect sximm8=16'hFFFE and writenum=1.
- ADD R2,R1,R0,LSL#1: in=16'hA148. Expect:
  - readnum=1 with loada=1
  - then readnum=0 with loadb=1
  - then loadc=1 with ALUop=00, shift=01, asel=0
  - then writenum=2 with write=1
  - w returns high after 6 edges.
- CMP R1,R0: in=16'hA900. Expect loads=1 in ALU, write never asserted, w high after 5 edges.
- Unsupported opcode: in=16'hE000 with s=1. Expect DECODE then WAIT and no strobes. Also drive in=16'hD0FF with load=1 while in GET_B of an earlier ADD; IR must remain unchanged.
- Reset during GET_B: assert reset between edges. Expect w=1, loadb=0, IR=0 immediately. After reset releases, s with no load takes the unsupported path, since IR=0 decodes as opcode 000.
